// File: rtl/tmr_mode_ctrl.sv
// Dynamic TMR mode controller: chooses simplex or full TMR from sensors, error rate
// and a force bit, with a warm-up phase before voting and a hold-off before returning.
module tmr_mode_ctrl #(
  parameter int unsigned N_SENS   = 4,
  parameter int unsigned SENS_THR = 3,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned ERR_THR  = 5,
  parameter int unsigned WARM_CYC = 4,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] sens_n,
  input  logic [ERR_W-1:0]  err_rate,
  input  logic              force_tmr,
  output logic [2:0]        en,
  output logic              state,
  output logic              vote_valid,
  output logic [1:0]        mode,
  output logic [CNT_W-1:0]  tmr_entries
);

  localparam int unsigned MAX_CYC = (WARM_CYC > HOLD_CYC) ? WARM_CYC : HOLD_CYC;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    SIMPLEX  = 2'b00,
    WARMUP   = 2'b01,
    TMR      = 2'b10,
    COOLDOWN = 2'b11
  } mode_e;

  mode_e            cur_q, cur_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] entries_q, entries_d;
  logic [31:0]      sens_cnt;
  logic             trigger;

  always_comb begin
    sens_cnt = '0;
    for (int unsigned i = 0; i < N_SENS; i++) begin
      sens_cnt = sens_cnt + 32'(!sens_n[i]);
    end
  end

  assign trigger = (sens_cnt >= SENS_THR) || (32'(err_rate) > ERR_THR) || force_tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q     <= SIMPLEX;
      cnt_q     <= '0;
      entries_q <= '0;
    end else begin
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      entries_q <= entries_d;
    end
  end

  always_comb begin
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    entries_d = entries_q;
    unique case (cur_q)
      SIMPLEX: begin
        if (trigger) begin
          cur_d = WARMUP;
          cnt_d = TW'(WARM_CYC - 1);
          if (entries_q != '1) entries_d = entries_q + CNT_W'(1);
        end
      end
      // Warm-up runs to completion regardless of trigger.
      WARMUP: begin
        if (cnt_q == '0) cur_d = TMR;
        else             cnt_d = cnt_q - TW'(1);
      end
      TMR: begin
        if (!trigger) begin
          cur_d = COOLDOWN;
          cnt_d = TW'(HOLD_CYC - 1);
        end
      end
      COOLDOWN: begin
        if (trigger)            cur_d = TMR;
        else if (cnt_q == '0)   cur_d = SIMPLEX;
        else                    cnt_d = cnt_q - TW'(1);
      end
      default: cur_d = SIMPLEX;
    endcase
  end

  assign mode        = cur_q;
  assign state       = (cur_q != SIMPLEX);
  assign en          = (cur_q == SIMPLEX) ? 3'b001 : 3'b111;
  assign vote_valid  = (cur_q == TMR) || (cur_q == COOLDOWN);
  assign tmr_entries = entries_q;

endmodule

// File: tb/tb_tmr_mode_ctrl.sv
// Randomized and directed checks of tmr_mode_ctrl against a cycle-count reference model.
module tb_tmr_mode_ctrl;

  localparam int unsigned N_SENS   = 4;
  localparam int unsigned SENS_THR = 3;
  localparam int unsigned ERR_THR  = 5;
  localparam int unsigned WARM_CYC = 4;
  localparam int unsigned HOLD_CYC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sens_n = 4'hF;
  logic [3:0] err_rate = '0;
  logic       force_tmr = 1'b0;

  logic [2:0] en, en_s;
  logic       state, state_s, vote_valid, vote_valid_s;
  logic [1:0] mode, mode_s;
  logic [7:0] tmr_entries;
  logic [1:0] tmr_entries_s;

  int vecs = 0;
  int errs = 0;

  // Model: redundant flag, warm-up cycles left, consecutive trigger-free cycles in TMR/COOLDOWN.
  bit          m_red   = 0;
  int          m_warm  = 0;
  int          m_quiet = 0;
  int unsigned m_ent   = 0;

  tmr_mode_ctrl dut (
    .clk(clk), .rst(rst), .sens_n(sens_n), .err_rate(err_rate), .force_tmr(force_tmr),
    .en(en), .state(state), .vote_valid(vote_valid), .mode(mode), .tmr_entries(tmr_entries)
  );

  tmr_mode_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sens_n(sens_n), .err_rate(err_rate), .force_tmr(force_tmr),
    .en(en_s), .state(state_s), .vote_valid(vote_valid_s), .mode(mode_s), .tmr_entries(tmr_entries_s)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_mode();
    if (!m_red)           return 2'd0;
    else if (m_warm > 0)  return 2'd1;
    else if (m_quiet == 0) return 2'd2;
    else                  return 2'd3;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [1:0] m;
    logic [7:0] e;
    m = exp_mode();
    e = (m_ent > 255) ? 8'd255 : 8'(m_ent);
    return {(m == 2'd0) ? 3'b001 : 3'b111, m != 2'd0, m[1], m, e};
  endfunction

  function automatic logic [1:0] exp_sat();
    return (m_ent > 3) ? 2'd3 : 2'(m_ent);
  endfunction

  task automatic tick();
    bit trig;
    trig = ($countones(~sens_n) >= SENS_THR) || (err_rate > ERR_THR) || force_tmr;
    @(posedge clk);
    if (rst) begin
      m_red = 0; m_warm = 0; m_quiet = 0; m_ent = 0;
    end else if (!m_red) begin
      if (trig) begin m_red = 1; m_warm = WARM_CYC; m_quiet = 0; m_ent++; end
    end else if (m_warm > 0) begin
      m_warm--;
    end else if (trig) begin
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet > HOLD_CYC) begin m_red = 0; m_quiet = 0; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sens_n = 4'hF; err_rate = '0; force_tmr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sens_n = 4'h0; err_rate = 4'd15; force_tmr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec() || mode !== 2'b00) begin
        errs++;
        $display("FAIL reset_hold: got %h want %h", {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (mode !== 2'b01 || {en, state, vote_valid, mode, tmr_entries} !== exp_vec()) begin
      errs++;
      $display("FAIL reset_release: got %h want %h", {en, state, vote_valid, mode, tmr_entries}, exp_vec());
    end
  endtask

  task automatic test_sensor_thr();
    do_reset();
    sens_n = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec() || mode !== 2'b00) begin
        errs++;
        $display("FAIL sens_two: got %h want %h", {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
    sens_n = 4'b1000;
    for (int i = 0; i < WARM_CYC + 1; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec()) begin
        errs++;
        $display("FAIL sens_three[%0d]: got %h want %h", i, {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
    vecs++;
    if (mode !== 2'b10 || vote_valid !== 1'b1 || tmr_entries !== 8'd1) begin
      errs++;
      $display("FAIL sens_tmr: got mode=%b vv=%b ent=%0d want 10 1 1", mode, vote_valid, tmr_entries);
    end
  endtask

  task automatic test_error_thr();
    do_reset();
    err_rate = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec() || mode !== 2'b00) begin
        errs++;
        $display("FAIL err_five: got %h want %h", {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
    err_rate = 4'd6;
    tick();
    err_rate = 4'd0;
    vecs++;
    if (mode !== 2'b01) begin
      errs++;
      $display("FAIL err_six: got mode=%b want 01", mode);
    end
    for (int i = 0; i < WARM_CYC + HOLD_CYC + 3; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec()) begin
        errs++;
        $display("FAIL err_pulse[%0d]: got %h want %h", i, {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
  endtask

  task automatic test_hysteresis();
    do_reset();
    force_tmr = 1'b1;
    for (int i = 0; i < WARM_CYC + 1; i++) tick();
    vecs++;
    if (mode !== 2'b10) begin
      errs++;
      $display("FAIL hyst_tmr: got mode=%b want 10", mode);
    end
    force_tmr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec() || en !== 3'b111) begin
        errs++;
        $display("FAIL hyst_cool[%0d]: got %h want %h", i, {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
    force_tmr = 1'b1;
    tick();
    vecs++;
    if (mode !== 2'b10 || en !== 3'b111) begin
      errs++;
      $display("FAIL hyst_reassert: got mode=%b en=%b want 10 111", mode, en);
    end
    force_tmr = 1'b0;
    for (int i = 1; i <= HOLD_CYC + 1; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec()
          || en !== ((i == HOLD_CYC + 1) ? 3'b001 : 3'b111)) begin
        errs++;
        $display("FAIL hyst_drop[%0d]: got %h want %h", i, {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    force_tmr = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec() || tmr_entries !== 8'd0) begin
        errs++;
        $display("FAIL reset_mid[%0d]: got %h want %h", i, {en, state, vote_valid, mode, tmr_entries}, exp_vec());
      end
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (mode !== 2'b01 || tmr_entries !== 8'd1) begin
      errs++;
      $display("FAIL reset_mid_release: got mode=%b ent=%0d want 01 1", mode, tmr_entries);
    end
    force_tmr = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      force_tmr = 1'b1;
      tick();
      force_tmr = 1'b0;
      for (int i = 0; i < WARM_CYC + HOLD_CYC + 2; i++) tick();
      vecs++;
      if (tmr_entries_s !== exp_sat() || mode_s !== exp_mode() || tmr_entries !== exp_vec()[7:0]) begin
        errs++;
        $display("FAIL saturation[%0d]: got %0d/%0d want %0d/%0d", n, tmr_entries_s, tmr_entries,
                 exp_sat(), exp_vec()[7:0]);
      end
    end
    vecs++;
    if (tmr_entries_s !== 2'd3 || tmr_entries !== 8'd5) begin
      errs++;
      $display("FAIL saturation_final: got %0d/%0d want 3/5", tmr_entries_s, tmr_entries);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      sens_n    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      err_rate  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      force_tmr = ($urandom_range(0, 15) == 0);
      tick();
      vecs++;
      if ({en, state, vote_valid, mode, tmr_entries} !== exp_vec()
          || {en_s, state_s, vote_valid_s, mode_s, tmr_entries_s} !== {exp_vec()[14:8], exp_sat()}) begin
        errs++;
        $display("FAIL random[%0d]: got %h/%h want %h/%h", i, {en, state, vote_valid, mode, tmr_entries},
                 tmr_entries_s, exp_vec(), exp_sat());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sensor_thr();
    test_error_thr();
    test_hysteresis();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
